// File: rtl/dbg_ocimem_ctrl.sv
// Debug scratch RAM controller: serves JTAG OCI memory commands and an Avalon-MM CPU port
// on a single shared RAM port, with a fairness flag so neither side starves.
module dbg_ocimem_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  // RAM contents are left to simulator initialisation; reset never touches them.
  if (ADDR_W < 1 || ADDR_W > 20 || INIT_ZERO > 1) begin : gen_bad_param
    $error("dbg_ocimem_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StJrd, StDone} state_e;
  typedef enum logic [1:0] {OpNop, OpRd, OpWr} op_e;

  state_e            state_q;
  op_e               slot_op_q, new_op;
  logic              slot_valid_q, fair_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       slot_data_q, ram_q, mon_dreg_q;
  logic              mon_ready_q, mon_error_q, rvalid_q;
  logic [31:0]       mem [Depth];

  logic              cpu_req, jtag_pend, grant_jtag, grant_cpu, strobe;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[35], jdo[2:0]};

  always_comb begin
    cpu_req    = avs_read | avs_write;
    jtag_pend  = (state_q == StIdle) && slot_valid_q && (slot_op_q != OpNop);
    grant_jtag = jtag_pend && (!cpu_req || fair_q);
    grant_cpu  = cpu_req && !grant_jtag && !reset &&
                 ((state_q == StIdle) || (state_q == StDone));
    ram_addr   = grant_jtag ? addr_q : avs_address;
    ram_wdata  = grant_jtag ? slot_data_q : avs_writedata;
    ram_be     = grant_jtag ? 4'hf : avs_byteenable;
    ram_we     = grant_jtag ? (slot_op_q == OpWr) : (grant_cpu && avs_write);
    ram_re     = grant_jtag ? (slot_op_q == OpRd) : (grant_cpu && !avs_write);
    strobe     = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
    if (take_action_ocimem_b)      new_op = OpWr;
    else if (take_action_ocimem_a) new_op = jdo[36] ? OpRd : OpNop;
    else                           new_op = OpRd;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ram_q <= '0;
    else if (ram_re) ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      slot_op_q    <= OpNop;
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      fair_q       <= 1'b0;
      addr_q       <= '0;
      mon_dreg_q   <= '0;
      mon_ready_q  <= 1'b1;
      mon_error_q  <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      rvalid_q <= grant_cpu && !avs_write;
      if (grant_cpu && jtag_pend) fair_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (grant_jtag) begin
            fair_q  <= 1'b0;
            state_q <= (slot_op_q == OpWr) ? StDone : StJrd;
          end else if (slot_valid_q && (slot_op_q == OpNop)) begin
            // Address-only command: nothing to do on the RAM.
            slot_valid_q <= 1'b0;
            mon_ready_q  <= 1'b1;
          end
        end
        StJrd: begin
          mon_dreg_q <= ram_q;
          state_q    <= StDone;
        end
        StDone: begin
          mon_ready_q  <= 1'b1;
          addr_q       <= addr_q + 1'b1;
          slot_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // An occupied slot means a command is queued or in flight; a new strobe is dropped.
      if (strobe) begin
        if (slot_valid_q) begin
          mon_error_q <= 1'b1;
        end else begin
          slot_valid_q <= 1'b1;
          slot_op_q    <= new_op;
          slot_data_q  <= jdo[34:3];
          mon_ready_q  <= 1'b0;
          if (!take_action_ocimem_b && take_action_ocimem_a) begin
            addr_q <= jdo[ADDR_W+16:17];
            if (jdo[37]) mon_error_q <= 1'b0;
          end
        end
      end
    end
  end

  assign MonDReg           = mon_dreg_q;
  assign monitor_ready     = mon_ready_q;
  assign monitor_error     = mon_error_q;
  assign avs_readdata      = ram_q;
  assign avs_readdatavalid = rvalid_q;
  assign avs_waitrequest   = reset | grant_jtag | (state_q == StJrd);

endmodule
